// File: rtl/seg_disp_arb.sv
// Arbitrates three clients onto one 6-digit hex display with a minimum hold
// time per owner, a blank gap between owners and optional client-0 preemption.
module seg_disp_arb #(
    parameter int CLK_PER_MS = 50000,
    parameter int HOLD_MS    = 1000,
    parameter int GAP_MS     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  req,
    input  logic [71:0] data_in,
    input  logic        pri_en,
    output logic [2:0]  gnt,
    output logic [23:0] disp_data,
    output logic        disp_en,
    output logic        busy
);

    localparam int MAX_MS = (HOLD_MS > GAP_MS) ? HOLD_MS : GAP_MS;
    localparam int PW     = $clog2(CLK_PER_MS);
    localparam int MW     = $clog2(MAX_MS + 1);

    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_MS - 1);
    localparam logic [MW-1:0] MS_MAX     = MW'(MAX_MS);
    localparam logic [MW-1:0] HOLD_C     = MW'(HOLD_MS);
    localparam logic [MW-1:0] GAP_LAST   = MW'(GAP_MS - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OWN  = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    logic [1:0]    r_state;
    logic [PW-1:0] r_presc;
    logic [MW-1:0] r_ms;
    logic [1:0]    r_owner;
    logic [1:0]    r_lastOwner;
    logic          r_prio;
    logic [2:0]    r_gnt;
    logic [23:0]   r_dispData;
    logic          r_dispEn;

    logic [1:0]    w_nextState;
    logic          w_enter;
    logic          w_tick;
    logic          w_ownerReq;
    logic          w_otherReq;
    logic          w_preempt;
    logic          w_ownExit;
    logic          w_gapDone;
    logic [1:0]    w_pick;
    logic [2:0]    w_pickOh;
    logic [23:0]   w_slice;

    assign w_tick     = (r_presc == PRESC_LAST);
    assign w_ownerReq = |(req & r_gnt);
    assign w_otherReq = |(req & ~r_gnt);
    assign w_preempt  = pri_en && req[0] && !r_gnt[0];
    assign w_ownExit  = (r_state == OWN) &&
                        (!w_ownerReq || w_preempt || ((r_ms >= HOLD_C) && w_otherReq));
    // Gap ends on the very edge the ms count would reach GAP_MS.
    assign w_gapDone  = (r_state == GAP) && w_tick && (r_ms == GAP_LAST);
    assign w_enter    = (w_nextState != r_state);
    assign w_pickOh   = 3'b001 << w_pick;

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (|req) w_nextState = OWN;
            OWN:     if (w_ownExit) w_nextState = GAP;
            GAP:     if (w_gapDone) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Round-robin search starts just above the previous owner; a pending
    // preemption forces client 0.
    always_comb begin
        case (r_lastOwner)
            2'd0:    w_pick = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
            2'd1:    w_pick = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
            default: w_pick = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
        endcase
        if (r_prio) w_pick = 2'd0;
    end

    always_comb begin
        case (r_owner)
            2'd0:    w_slice = data_in[23:0];
            2'd1:    w_slice = data_in[47:24];
            default: w_slice = data_in[71:48];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_ms    <= '0;
        end else if (w_enter || w_tick) begin
            r_presc <= '0;
            if (w_enter) r_ms <= '0;
            else if (r_ms != MS_MAX) r_ms <= r_ms + 1'b1;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_owner     <= 2'd0;
            r_lastOwner <= 2'd2;
            r_prio      <= 1'b0;
            r_gnt       <= 3'b000;
            r_dispData  <= 24'h0;
            r_dispEn    <= 1'b0;
        end else begin
            r_state <= w_nextState;
            case (r_state)
                IDLE: begin
                    if (|req) begin
                        r_owner <= w_pick;
                        r_gnt   <= w_pickOh;
                        r_prio  <= 1'b0;
                    end
                end
                OWN: begin
                    if (w_ownExit) begin
                        r_lastOwner <= r_owner;
                        r_gnt       <= 3'b000;
                        r_dispEn    <= 1'b0;
                        // An owner release wins over a simultaneous preemption.
                        r_prio      <= w_preempt && w_ownerReq;
                    end else begin
                        r_dispData <= w_slice;
                        r_dispEn   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign disp_data = r_dispData;
    assign disp_en   = r_dispEn;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_seg_disp_arb.sv
// Scenario tasks for seg_disp_arb plus a randomized run checked against a
// cycle-count based reference model of the ownership/gap rules.
module tb_seg_disp_arb;

    localparam int CPM  = 4;
    localparam int HOLD = 3;
    localparam int GAPM = 1;

    logic        clk;
    logic        rst_n;
    logic [2:0]  req;
    logic [71:0] data_in;
    logic        pri_en;
    logic [2:0]  gnt;
    logic [23:0] disp_data;
    logic        disp_en;
    logic        busy;

    int errors = 0;
    int checks = 0;

    int          mOwner;
    bit          mGap;
    int          mCnt;
    int          mLast;
    bit          mPrio;
    logic [23:0] mData;
    bit          mEn;

    seg_disp_arb #(
        .CLK_PER_MS(CPM),
        .HOLD_MS(HOLD),
        .GAP_MS(GAPM)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .data_in(data_in),
        .pri_en(pri_en),
        .gnt(gnt),
        .disp_data(disp_data),
        .disp_en(disp_en),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic doReset();
        @(negedge clk);
        rst_n  = 1'b0;
        req    = 3'b000;
        pri_en = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic modelReset();
        mOwner = -1;
        mGap   = 1'b0;
        mCnt   = 0;
        mLast  = 2;
        mPrio  = 1'b0;
        mData  = 24'h0;
        mEn    = 1'b0;
    endtask

    // Time is tracked as plain clock cycles spent in the current phase.
    task automatic modelStep();
        int   w;
        bit   found;
        logic ownReq, others, pre, held;
        if (mGap) begin
            if (mCnt + 1 >= GAPM * CPM) begin
                mGap = 1'b0;
                mCnt = 0;
            end else begin
                mCnt++;
            end
        end else if (mOwner < 0) begin
            if (req != 3'b000) begin
                w = 0;
                found = 1'b0;
                if (!mPrio) begin
                    for (int k = 1; k <= 3; k++) begin
                        if (!found && req[(mLast + k) % 3]) begin
                            w = (mLast + k) % 3;
                            found = 1'b1;
                        end
                    end
                end
                mOwner = w;
                mPrio  = 1'b0;
                mCnt   = 0;
            end
        end else begin
            ownReq = req[mOwner];
            others = |(req & ~(3'b001 << mOwner));
            pre    = pri_en && req[0] && (mOwner != 0);
            held   = (mCnt >= HOLD * CPM);
            if (!ownReq || pre || (held && others)) begin
                mPrio  = pre && ownReq;
                mLast  = mOwner;
                mOwner = -1;
                mGap   = 1'b1;
                mCnt   = 0;
                mEn    = 1'b0;
            end else begin
                mData = data_in[mOwner*24 +: 24];
                mEn   = 1'b1;
                mCnt++;
            end
        end
    endtask

    task automatic test_reset();
        req     = 3'b111;
        pri_en  = 1'b1;
        data_in = '1;
        #2;
        for (int p = 0; p < 2; p++) begin
            checks += 4;
            if (gnt !== 3'b000) begin
                errors++; $display("[TB] FAIL reset_gnt pass %0d: got %b expected 000", p, gnt);
            end
            if (disp_en !== 1'b0) begin
                errors++; $display("[TB] FAIL reset_en pass %0d: got %b expected 0", p, disp_en);
            end
            if (disp_data !== 24'h0) begin
                errors++; $display("[TB] FAIL reset_data pass %0d: got %h expected 000000", p, disp_data);
            end
            if (busy !== 1'b0) begin
                errors++; $display("[TB] FAIL reset_busy pass %0d: got %b expected 0", p, busy);
            end
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic test_basic();
        doReset();
        data_in = '0;
        data_in[47:24] = 24'h123456;
        req = 3'b010;
        @(negedge clk);
        checks += 2;
        if (gnt !== 3'b010) begin
            errors++; $display("[TB] FAIL basic_gnt: got %b expected 010", gnt);
        end
        if (disp_en !== 1'b0) begin
            errors++; $display("[TB] FAIL basic_en_early: got %b expected 0", disp_en);
        end
        @(negedge clk);
        checks += 3;
        if (disp_data !== 24'h123456) begin
            errors++; $display("[TB] FAIL basic_data: got %h expected 123456", disp_data);
        end
        if (disp_en !== 1'b1) begin
            errors++; $display("[TB] FAIL basic_en: got %b expected 1", disp_en);
        end
        if (busy !== 1'b1) begin
            errors++; $display("[TB] FAIL basic_busy: got %b expected 1", busy);
        end
    endtask

    task automatic test_hold();
        int cnt;
        doReset();
        req = 3'b010;
        @(negedge clk);
        req = 3'b110;
        cnt = 0;
        while (gnt === 3'b010 && cnt < 60) begin
            cnt++;
            @(negedge clk);
        end
        checks++;
        if (cnt != HOLD * CPM + 1) begin
            errors++; $display("[TB] FAIL hold_len: got %0d cycles expected %0d", cnt, HOLD * CPM + 1);
        end
        cnt = 0;
        while (busy === 1'b1 && gnt === 3'b000 && disp_en === 1'b0 && cnt < 60) begin
            cnt++;
            @(negedge clk);
        end
        checks += 2;
        if (cnt != GAPM * CPM) begin
            errors++; $display("[TB] FAIL hold_gap: got %0d cycles expected %0d", cnt, GAPM * CPM);
        end
        if (busy !== 1'b0 || gnt !== 3'b000) begin
            errors++; $display("[TB] FAIL hold_idle: got busy=%b gnt=%b expected busy=0 gnt=000", busy, gnt);
        end
        @(negedge clk);
        checks++;
        if (gnt !== 3'b100) begin
            errors++; $display("[TB] FAIL hold_next: got %b expected 100", gnt);
        end
    endtask

    task automatic test_rotation();
        int order [4] = '{0, 1, 2, 0};
        int cnt;
        int gapCnt;
        logic [2:0] want;
        doReset();
        req = 3'b111;
        gapCnt = 0;
        for (int i = 0; i < 4; i++) begin
            cnt = 0;
            while (gnt === 3'b000 && cnt < 40) begin
                cnt++;
                @(negedge clk);
            end
            want = 3'b001 << order[i];
            checks++;
            if (gnt !== want) begin
                errors++; $display("[TB] FAIL rot_gnt%0d: got %b expected %b", i, gnt, want);
            end
            if (i > 0) begin
                checks++;
                if (gapCnt != GAPM * CPM) begin
                    errors++; $display("[TB] FAIL rot_gap%0d: got %0d cycles expected %0d", i, gapCnt, GAPM * CPM);
                end
            end
            req = 3'b111 & ~gnt;
            @(negedge clk);
            req = 3'b111;
            gapCnt = 0;
            while (busy === 1'b1 && gnt === 3'b000 && gapCnt < 40) begin
                gapCnt++;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_preempt();
        int cnt;
        doReset();
        req = 3'b100;
        repeat (5) @(negedge clk);
        pri_en = 1'b1;
        req = 3'b101;
        @(negedge clk);
        checks++;
        if (gnt !== 3'b000 || busy !== 1'b1) begin
            errors++; $display("[TB] FAIL pre_exit: got gnt=%b busy=%b expected gnt=000 busy=1", gnt, busy);
        end
        cnt = 0;
        while (gnt === 3'b000 && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        checks++;
        if (gnt !== 3'b001) begin
            errors++; $display("[TB] FAIL pre_gnt: got %b expected 001", gnt);
        end

        doReset();
        req = 3'b100;
        @(negedge clk);
        cnt = 0;
        while (gnt === 3'b100 && cnt < 60) begin
            cnt++;
            if (cnt == 5) req = 3'b101;
            @(negedge clk);
        end
        checks++;
        if (cnt != HOLD * CPM + 1) begin
            errors++; $display("[TB] FAIL nopre_len: got %0d cycles expected %0d", cnt, HOLD * CPM + 1);
        end

        // Owner 1 preempted while 2 also requests: plain round-robin would pick 2.
        doReset();
        req = 3'b010;
        repeat (2) @(negedge clk);
        pri_en = 1'b1;
        req = 3'b111;
        @(negedge clk);
        cnt = 0;
        while (gnt === 3'b000 && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        checks++;
        if (gnt !== 3'b001) begin
            errors++; $display("[TB] FAIL pre_rr_gnt: got %b expected 001", gnt);
        end
        pri_en = 1'b0;
    endtask

    task automatic test_coincide();
        int cnt;
        doReset();
        req = 3'b010;
        repeat (2) @(negedge clk);
        pri_en = 1'b1;
        req = 3'b101;
        @(negedge clk);
        pri_en = 1'b0;
        cnt = 0;
        while (busy === 1'b1 && gnt === 3'b000 && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        checks++;
        if (cnt != GAPM * CPM) begin
            errors++; $display("[TB] FAIL coin_gap: got %0d cycles expected %0d", cnt, GAPM * CPM);
        end
        @(negedge clk);
        checks++;
        if (gnt !== 3'b100) begin
            errors++; $display("[TB] FAIL coin_gnt: got %b expected 100", gnt);
        end
    endtask

    task automatic test_async_reset();
        doReset();
        data_in[47:24] = 24'hABCDEF;
        req = 3'b010;
        repeat (3) @(negedge clk);
        checks++;
        if (disp_data !== 24'hABCDEF || disp_en !== 1'b1) begin
            errors++; $display("[TB] FAIL ar_pre: got data=%h en=%b expected abcdef/1", disp_data, disp_en);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks += 4;
        if (gnt !== 3'b000) begin
            errors++; $display("[TB] FAIL ar_gnt: got %b expected 000", gnt);
        end
        if (disp_en !== 1'b0) begin
            errors++; $display("[TB] FAIL ar_en: got %b expected 0", disp_en);
        end
        if (disp_data !== 24'h0) begin
            errors++; $display("[TB] FAIL ar_data: got %h expected 000000", disp_data);
        end
        if (busy !== 1'b0) begin
            errors++; $display("[TB] FAIL ar_busy: got %b expected 0", busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        req = 3'b111;
        @(negedge clk);
        checks++;
        if (gnt !== 3'b001) begin
            errors++; $display("[TB] FAIL ar_first: got %b expected 001", gnt);
        end
    endtask

    task automatic test_random();
        logic [2:0] expGnt;
        doReset();
        modelReset();
        req = 3'b000;
        for (int c = 0; c < 2000; c++) begin
            for (int b = 0; b < 3; b++) begin
                if ($urandom_range(0, 9) == 0) req[b] = ~req[b];
            end
            if ($urandom_range(0, 15) == 0) pri_en = ~pri_en;
            data_in[31:0]  = $urandom();
            data_in[63:32] = $urandom();
            data_in[71:64] = 8'($urandom());
            @(posedge clk);
            modelStep();
            @(negedge clk);
            expGnt = (mOwner >= 0) ? (3'b001 << mOwner) : 3'b000;
            checks += 4;
            if (gnt !== expGnt) begin
                errors++; $display("[TB] FAIL rand_gnt cycle %0d: got %b expected %b", c, gnt, expGnt);
            end
            if (disp_en !== mEn) begin
                errors++; $display("[TB] FAIL rand_en cycle %0d: got %b expected %b", c, disp_en, mEn);
            end
            if (disp_data !== mData) begin
                errors++; $display("[TB] FAIL rand_data cycle %0d: got %h expected %h", c, disp_data, mData);
            end
            if (busy !== (mGap || mOwner >= 0)) begin
                errors++; $display("[TB] FAIL rand_busy cycle %0d: got %b expected %b", c, busy, (mGap || mOwner >= 0));
            end
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        req     = 3'b000;
        pri_en  = 1'b0;
        data_in = '0;
        test_reset();
        test_basic();
        test_hold();
        test_rotation();
        test_preempt();
        test_coincide();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
